// File: rtl/piece_dropper.sv
// Falling-piece controller: fetches a 4x8 shape, spawns it at row 0, moves/drops it, locks it into the board.
// Piece visible in frame two cycles after start; drop/move pulses act only in FALL, start only in IDLE.
module piece_dropper #(
    parameter int ROWS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [1:0]           next_shape,
    output logic [1:0]           shape_addr,
    input  logic [3:0][7:0]      shape,
    input  logic                 drop_tick,
    input  logic                 move_left,
    input  logic                 move_right,
    output logic [ROWS-1:0][7:0] board,
    output logic [ROWS-1:0][7:0] frame,
    output logic                 busy,
    output logic                 locked,
    output logic                 game_over
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] R_MAX = RW'(ROWS - 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SPAWN,
        S_FALL,
        S_LOCK,
        S_OVER
    } state_t;

    state_t               r_state;
    logic [1:0]           r_shape_addr;
    logic [ROWS-1:0][7:0] r_board;
    logic [3:0][7:0]      r_p;
    logic [RW-1:0]        r_row;

    logic [3:0][7:0]      w_cur;
    logic [3:0][7:0]      w_below;
    logic [ROWS-1:0][7:0] w_merged;
    logic                 w_hit_cur;
    logic                 w_hit_below;
    logic                 w_hit_l;
    logic                 w_hit_r;
    logic                 w_edge_l;
    logic                 w_edge_r;
    logic                 w_drop_ok;
    logic                 w_left_ok;
    logic                 w_right_ok;
    logic                 w_show;

    // Piece row i sits on board row r+3-i; the row below it is r+4-i.
    always_comb begin
        w_cur       = '0;
        w_below     = '0;
        w_merged    = r_board;
        w_hit_cur   = 1'b0;
        w_hit_below = 1'b0;
        w_hit_l     = 1'b0;
        w_hit_r     = 1'b0;
        w_edge_l    = 1'b0;
        w_edge_r    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_cur[i]   = r_board[r_row + RW'(3 - i)];
            w_below[i] = r_board[r_row + RW'(4 - i)];
            w_merged[r_row + RW'(3 - i)] = r_board[r_row + RW'(3 - i)] | r_p[i];
            w_hit_cur   = w_hit_cur   | (|(r_p[i] & w_cur[i]));
            w_hit_below = w_hit_below | (|(r_p[i] & w_below[i]));
            w_hit_l     = w_hit_l     | (|((r_p[i] << 1) & w_cur[i]));
            w_hit_r     = w_hit_r     | (|((r_p[i] >> 1) & w_cur[i]));
            w_edge_l    = w_edge_l    | r_p[i][7];
            w_edge_r    = w_edge_r    | r_p[i][0];
        end
        // The below-window index wraps at the floor; the row limit masks it.
        w_drop_ok  = (r_row < R_MAX) && !w_hit_below;
        w_left_ok  = !w_edge_l && !w_hit_l;
        w_right_ok = !w_edge_r && !w_hit_r;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_shape_addr <= '0;
            r_board      <= '0;
            r_p          <= '0;
            r_row        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shape_addr <= next_shape;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_p     <= shape;
                    r_row   <= '0;
                    r_state <= S_SPAWN;
                end
                S_SPAWN: begin
                    r_state <= w_hit_cur ? S_OVER : S_FALL;
                end
                S_FALL: begin
                    if (drop_tick) begin
                        if (w_drop_ok) r_row   <= r_row + RW'(1);
                        else           r_state <= S_LOCK;
                    end else if (move_left) begin
                        if (w_left_ok) begin
                            for (int i = 0; i < 4; i++) r_p[i] <= r_p[i] << 1;
                        end
                    end else if (move_right) begin
                        if (w_right_ok) begin
                            for (int i = 0; i < 4; i++) r_p[i] <= r_p[i] >> 1;
                        end
                    end
                end
                S_LOCK: begin
                    r_board <= w_merged;
                    r_state <= S_IDLE;
                end
                S_OVER: begin
                    r_state <= S_OVER;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_show     = (r_state == S_SPAWN) || (r_state == S_FALL) ||
                        (r_state == S_LOCK)  || (r_state == S_OVER);
    assign shape_addr = r_shape_addr;
    assign board      = r_board;
    assign frame      = w_show ? w_merged : r_board;
    assign busy       = (r_state == S_FETCH) || (r_state == S_SPAWN) ||
                        (r_state == S_FALL)  || (r_state == S_LOCK);
    assign locked     = (r_state == S_LOCK);
    assign game_over  = (r_state == S_OVER);

endmodule

// File: tb/tb_piece_dropper.sv
// Directed bench for piece_dropper with a small shape ROM and a hand-tracked expected board.
module tb_piece_dropper;

    localparam int ROWS = 16;
    localparam logic [3:0][7:0] SQ    = {8'h00, 8'h00, 8'h18, 8'h18};
    localparam logic [3:0][7:0] LINE  = {8'h10, 8'h10, 8'h10, 8'h10};
    localparam logic [3:0][7:0] WALL  = {8'h80, 8'h80, 8'h80, 8'h80};
    localparam logic [3:0][7:0] TEE   = {8'h00, 8'h00, 8'h10, 8'h38};
    localparam logic [3:0][7:0] TEE_L = {8'h00, 8'h00, 8'h20, 8'h70};

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start;
    logic [1:0]           next_shape;
    logic [1:0]           shape_addr;
    logic [3:0][7:0]      shape;
    logic                 drop_tick;
    logic                 move_left;
    logic                 move_right;
    logic [ROWS-1:0][7:0] board;
    logic [ROWS-1:0][7:0] frame;
    logic                 busy;
    logic                 locked;
    logic                 game_over;

    int checks = 0;
    int errors = 0;
    logic [ROWS-1:0][7:0] exp_board;

    piece_dropper #(.ROWS(ROWS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .next_shape (next_shape),
        .shape_addr (shape_addr),
        .shape      (shape),
        .drop_tick  (drop_tick),
        .move_left  (move_left),
        .move_right (move_right),
        .board      (board),
        .frame      (frame),
        .busy       (busy),
        .locked     (locked),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (shape_addr)
            2'd0:    shape = SQ;
            2'd1:    shape = LINE;
            2'd2:    shape = '0;
            default: shape = TEE;
        endcase
    end

    function automatic logic [ROWS-1:0][7:0] overlay(input logic [ROWS-1:0][7:0] b,
                                                     input logic [3:0][7:0] p, input int r);
        logic [3:0] idx;
        overlay = b;
        for (int i = 0; i < 4; i++) begin
            idx = 4'(r + 3 - i);
            overlay[idx] = b[idx] | p[i];
        end
    endfunction

    // All helpers start and end just after a falling edge.
    task automatic step(input logic d, input logic l, input logic r);
        drop_tick = d; move_left = l; move_right = r;
        @(negedge clk);
        drop_tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic launch(input logic [1:0] s);
        start = 1'b1; next_shape = s;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; next_shape = 2'd0;
        drop_tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
        exp_board = '0;
        repeat (2) @(negedge clk);
        checks++; if (board !== exp_board) begin errors++; $display("FAIL reset_board: got %h want %h", board, exp_board); end
        checks++; if (frame !== exp_board) begin errors++; $display("FAIL reset_frame: got %h want %h", frame, exp_board); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        checks++; if (shape_addr !== 2'd0) begin errors++; $display("FAIL reset_shape_addr: got %0d want 0", shape_addr); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_square_drop();
        start = 1'b1; next_shape = 2'd0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sq_fetch_busy: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (frame !== overlay(exp_board, SQ, 0)) begin errors++; $display("FAIL sq_spawn_frame: got %h want %h", frame, overlay(exp_board, SQ, 0)); end
        @(negedge clk);
        start = 1'b1; next_shape = 2'd3;
        @(negedge clk);
        start = 1'b0;
        checks++; if (shape_addr !== 2'd0) begin errors++; $display("FAIL sq_start_ignored: got %0d want 0", shape_addr); end
        repeat (12) tick();
        checks++; if (frame !== overlay(exp_board, SQ, 12)) begin errors++; $display("FAIL sq_r12_frame: got %h want %h", frame, overlay(exp_board, SQ, 12)); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sq_r12_locked: got %b want 0", locked); end
        tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sq_lock_pulse: got %b want 1", locked); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sq_lock_busy: got %b want 1", busy); end
        @(negedge clk);
        exp_board[14] = 8'h18; exp_board[15] = 8'h18;
        checks++; if (board !== exp_board) begin errors++; $display("FAIL sq_board: got %h want %h", board, exp_board); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sq_idle_locked: got %b want 0", locked); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sq_idle_busy: got %b want 0", busy); end
        checks++; if (frame !== exp_board) begin errors++; $display("FAIL sq_idle_frame: got %h want %h", frame, exp_board); end
    endtask

    task automatic test_stacking();
        launch(2'd0);
        repeat (10) tick();
        checks++; if (frame !== overlay(exp_board, SQ, 10)) begin errors++; $display("FAIL stack_r10_frame: got %h want %h", frame, overlay(exp_board, SQ, 10)); end
        tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stack_lock_pulse: got %b want 1", locked); end
        @(negedge clk);
        exp_board[12] = 8'h18; exp_board[13] = 8'h18;
        checks++; if (board !== exp_board) begin errors++; $display("FAIL stack_board: got %h want %h", board, exp_board); end
    endtask

    task automatic test_reset_mid_fall();
        launch(2'd1);
        repeat (5) tick();
        checks++; if (frame !== overlay(exp_board, LINE, 5)) begin errors++; $display("FAIL midrst_r5_frame: got %h want %h", frame, overlay(exp_board, LINE, 5)); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (board !== '0) begin errors++; $display("FAIL midrst_board: got %h want 0", board); end
        checks++; if (frame !== '0) begin errors++; $display("FAIL midrst_frame: got %h want 0", frame); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (shape_addr !== 2'd0) begin errors++; $display("FAIL midrst_shape_addr: got %0d want 0", shape_addr); end
        checks++; if (locked !== 1'b0 || game_over !== 1'b0) begin errors++; $display("FAIL midrst_flags: got locked=%b game_over=%b want 0 0", locked, game_over); end
        @(negedge clk);
        reset_n = 1'b1;
        exp_board = '0;
        @(negedge clk);
    endtask

    task automatic test_line_wall();
        start = 1'b1; next_shape = 2'd1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (shape_addr !== 2'd1) begin errors++; $display("FAIL wall_shape_addr: got %0d want 1", shape_addr); end
        @(negedge clk);
        checks++; if (frame !== overlay(exp_board, LINE, 0)) begin errors++; $display("FAIL wall_spawn_frame: got %h want %h", frame, overlay(exp_board, LINE, 0)); end
        @(negedge clk);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        checks++; if (frame !== overlay(exp_board, WALL, 0)) begin errors++; $display("FAIL wall_left3: got %h want %h", frame, overlay(exp_board, WALL, 0)); end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (frame !== overlay(exp_board, WALL, 0)) begin errors++; $display("FAIL wall_left4_blocked: got %h want %h", frame, overlay(exp_board, WALL, 0)); end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 1'b0, 1'b1);
        checks++; if (frame !== overlay(exp_board, WALL, 1)) begin errors++; $display("FAIL simul_drop_right: got %h want %h", frame, overlay(exp_board, WALL, 1)); end
        repeat (11) tick();
        tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wall_lock_pulse: got %b want 1", locked); end
        @(negedge clk);
        for (int k = 12; k < 16; k++) exp_board[k] = 8'h80;
        checks++; if (board !== exp_board) begin errors++; $display("FAIL wall_board: got %h want %h", board, exp_board); end
    endtask

    task automatic test_both_moves();
        launch(2'd3);
        step(1'b0, 1'b1, 1'b1);
        checks++; if (frame !== overlay(exp_board, TEE_L, 0)) begin errors++; $display("FAIL both_left_wins: got %h want %h", frame, overlay(exp_board, TEE_L, 0)); end
        step(1'b0, 1'b0, 1'b1);
        checks++; if (frame !== overlay(exp_board, TEE, 0)) begin errors++; $display("FAIL right_move: got %h want %h", frame, overlay(exp_board, TEE, 0)); end
        repeat (12) tick();
        tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL tee_lock_pulse: got %b want 1", locked); end
        @(negedge clk);
        exp_board[14] = 8'h90; exp_board[15] = 8'hB8;
        checks++; if (board !== exp_board) begin errors++; $display("FAIL tee_board: got %h want %h", board, exp_board); end
    endtask

    task automatic test_empty();
        launch(2'd2);
        checks++; if (frame !== exp_board) begin errors++; $display("FAIL empty_frame: got %h want %h", frame, exp_board); end
        repeat (12) tick();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL empty_r12_locked: got %b want 0", locked); end
        tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL empty_lock_pulse: got %b want 1", locked); end
        @(negedge clk);
        checks++; if (board !== exp_board) begin errors++; $display("FAIL empty_board: got %h want %h", board, exp_board); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_game_over();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_board = '0;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            launch(2'd0);
            repeat (12 - 2 * k) tick();
            tick();
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL go_lock_%0d: got %b want 1", k, locked); end
            @(negedge clk);
            exp_board[14 - 2 * k] = 8'h18;
            exp_board[15 - 2 * k] = 8'h18;
        end
        checks++; if (board !== exp_board) begin errors++; $display("FAIL go_stack_board: got %h want %h", board, exp_board); end
        start = 1'b1; next_shape = 2'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (game_over !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL go_cycle2: got game_over=%b busy=%b want 0 1", game_over, busy); end
        @(negedge clk);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_cycle3_game_over: got %b want 1", game_over); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL go_cycle3_busy: got %b want 0", busy); end
        checks++; if (frame !== exp_board) begin errors++; $display("FAIL go_frame: got %h want %h", frame, exp_board); end
        start = 1'b1; next_shape = 2'd1;
        @(negedge clk);
        start = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (game_over !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL go_sticky: got game_over=%b busy=%b want 1 0", game_over, busy); end
        checks++; if (shape_addr !== 2'd0) begin errors++; $display("FAIL go_start_ignored: got %0d want 0", shape_addr); end
        checks++; if (board !== exp_board) begin errors++; $display("FAIL go_board_hold: got %h want %h", board, exp_board); end
    endtask

    initial begin
        test_reset();
        test_square_drop();
        test_stacking();
        test_reset_mid_fall();
        test_line_wall();
        test_simultaneous();
        test_both_moves();
        test_empty();
        test_game_over();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
